// File: rtl/clock_adjust_ctrl.sv
// Clock-chain sequencer: 1 Hz prescaler, adjust-field FSM, debounced key1/key2/key3 handling.
// Optional key2/key3 auto-repeat is compiled in when CLOCK_ADJ_AUTO_REPEAT_EN is defined.
module clock_adjust_ctrl #(
   parameter int CLK_HZ  = 50_000_000,
   parameter int DEB_CYC = 1_000_000,
   parameter int REP_DLY = 25_000_000,
   parameter int REP_PER = 5_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_sw17,
   input  logic       i_key1_n,
   input  logic       i_key2_n,
   input  logic       i_key3_n,
   output logic       o_tick_1hz,
   output logic       o_sec_en,
   output logic [1:0] o_adjust,
   output logic       o_key2,
   output logic       o_key3,
   output logic       o_blink
);

   localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
   localparam logic [PW-1:0] PRE_MAX  = PW'(CLK_HZ - 1);
   localparam logic [PW-1:0] PRE_HALF = PW'(CLK_HZ / 2);
   localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CYC - 1);

   if (CLK_HZ < 2 || DEB_CYC < 1 || REP_DLY < 1 || REP_PER < 1) begin : g_param_check
      $error("clock_adjust_ctrl: parameter out of range");
   end

   // Encoding chosen so the state value is directly the adjust field code.
   typedef enum logic [1:0] {
      ST_ADJ_SEC  = 2'd0,
      ST_ADJ_MIN  = 2'd1,
      ST_ADJ_HOUR = 2'd2,
      ST_RUN      = 2'd3
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [PW-1:0] r_presc;
   logic          w_presc_clr;

   logic [2:0]    w_raw;
   logic [2:0]    r_sync1;
   logic [2:0]    r_sync2;
   logic [2:0]    r_deb;
   logic [2:0]    r_deb_d;
   logic [DW-1:0] r_deb_cnt [3];
   logic [2:0]    w_press;
   logic [1:0]    w_rep;

   logic          w_inc_evt;
   logic          w_dec_evt;
   logic          w_adj_active;
   logic          w_key2_nxt;
   logic          w_key3_nxt;
   logic          r_key2;
   logic          r_key3;

   assign w_raw = {i_key3_n, i_key2_n, i_key1_n};

   // Counter runs only while the synchronized level differs from the accepted one,
   // so any bounce back to the accepted level restarts the stability window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= '1;
         r_sync2 <= '1;
         r_deb   <= '1;
         r_deb_d <= '1;
         for (int k = 0; k < 3; k++) begin
            r_deb_cnt[k] <= '0;
         end
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
         r_deb_d <= r_deb;
         for (int k = 0; k < 3; k++) begin
            if (r_sync2[k] == r_deb[k]) begin
               r_deb_cnt[k] <= '0;
            end else if (r_deb_cnt[k] == DEB_MAX) begin
               r_deb[k]     <= r_sync2[k];
               r_deb_cnt[k] <= '0;
            end else begin
               r_deb_cnt[k] <= r_deb_cnt[k] + 1'b1;
            end
         end
      end
   end

   assign w_press = r_deb_d & ~r_deb;

`ifdef CLOCK_ADJ_AUTO_REPEAT_EN
   localparam int RMAX = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
   localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
   localparam logic [RW-1:0] REP_DLY_MAX = RW'(REP_DLY - 1);
   localparam logic [RW-1:0] REP_PER_MAX = RW'(REP_PER - 1);

   // Index 0 tracks key2, index 1 tracks key3.
   logic [RW-1:0] r_rep_cnt [2];
   logic [1:0]    r_rep_per;

   always_comb begin
      w_rep = '0;
      for (int j = 0; j < 2; j++) begin
         if (!r_deb[j+1] && !w_press[j+1]) begin
            w_rep[j] = r_rep_per[j] ? (r_rep_cnt[j] == REP_PER_MAX)
                                    : (r_rep_cnt[j] == REP_DLY_MAX);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rep_per <= '0;
         for (int j = 0; j < 2; j++) begin
            r_rep_cnt[j] <= '0;
         end
      end else begin
         for (int j = 0; j < 2; j++) begin
            if (r_deb[j+1] || w_press[j+1]) begin
               r_rep_cnt[j] <= '0;
               r_rep_per[j] <= 1'b0;
            end else if (w_rep[j]) begin
               r_rep_cnt[j] <= '0;
               r_rep_per[j] <= 1'b1;
            end else begin
               r_rep_cnt[j] <= r_rep_cnt[j] + 1'b1;
            end
         end
      end
   end
`else
   assign w_rep = '0;
`endif

   assign w_inc_evt    = w_press[1] | w_rep[0];
   assign w_dec_evt    = w_press[2] | w_rep[1];
   assign w_adj_active = i_sw17 && (r_state != ST_RUN);
   // key1 and opposing inc/dec events cancel the pulse.
   assign w_key2_nxt   = w_adj_active && w_inc_evt && !w_dec_evt && !w_press[0];
   assign w_key3_nxt   = w_adj_active && w_dec_evt && !w_inc_evt && !w_press[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_RUN;
         r_presc <= '0;
         r_key2  <= 1'b0;
         r_key3  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_key2  <= w_key2_nxt;
         r_key3  <= w_key3_nxt;
         if (w_presc_clr || r_presc == PRE_MAX) begin
            r_presc <= '0;
         end else begin
            r_presc <= r_presc + 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (!i_sw17) begin
         w_state_nxt = ST_RUN;
      end else if (w_press[0]) begin
         case (r_state)
            ST_RUN:      w_state_nxt = ST_ADJ_SEC;
            ST_ADJ_SEC:  w_state_nxt = ST_ADJ_MIN;
            ST_ADJ_MIN:  w_state_nxt = ST_ADJ_HOUR;
            default:     w_state_nxt = ST_RUN;
         endcase
      end
      // Leaving adjust restarts the second so the first one after is full length.
      w_presc_clr = (r_state != ST_RUN) && (w_state_nxt == ST_RUN);
      o_adjust    = r_state;
      o_tick_1hz  = (r_presc == PRE_MAX);
      o_sec_en    = (r_presc == PRE_MAX) && (r_state == ST_RUN);
      o_blink     = (r_presc < PRE_HALF) && (r_state != ST_RUN);
   end

   assign o_key2 = r_key2;
   assign o_key3 = r_key3;

endmodule

// File: doc/clock_adjust_ctrl.md
# clock_adjust_ctrl

Sequencer for the digital-clock counter chain (seconds/minutes/hours). Generates the 1 Hz count enable, runs the adjust-mode state machine that selects which counter field is being set, and turns raw push-buttons into clean single-cycle increment/decrement pulses. Its outputs drive the `en`, `adjust`, `key2` and `key3` inputs of every time counter; each counter compares `adjust` against its own fixed `mode` code.

## Interface
- `CLK_HZ`, default 50_000_000: clk cycles per second; prescaler period.
- `DEB_CYC`, default 1_000_000: consecutive stable synchronized cycles required to accept a button level change.
- `REP_DLY`, default 25_000_000: hold time in cycles before auto-repeat starts.
- `REP_PER`, default 5_000_000: cycles between auto-repeat pulses.
- `clk  in  1`: system clock.
- `rst_n  in  1`: reset, asynchronous, active-low.
- `sw17  in  1`: adjust enable switch; 0 forces RUN.
- `key1_n  in  1`: raw button, active-low; advances the adjusted field.
- `key2_n  in  1`: raw button, active-low; increment.
- `key3_n  in  1`: raw button, active-low; decrement.
- `tick_1hz  out  1`: one-cycle pulse once per second, free-running.
- `sec_en  out  1`: count enable to the seconds counter.
- `adjust  out  2`: field select: 2'd0 sec, 2'd1 min, 2'd2 hour, 2'd3 none.
- `key2  out  1`: one-cycle increment pulse.
- `key3  out  1`: one-cycle decrement pulse.
- `blink  out  1`: display blanking enable for the selected field.

## Operation
- Button path, per key: 2-flop synchronizer; debounce counter reloads on any change of the synchronized level; debounced level updates when the synchronized level has been stable for DEB_CYC cycles. Press event = debounced level 1->0.
- FSM states: RUN, ADJ_SEC, ADJ_MIN, ADJ_HOUR.
  - RUN -> ADJ_SEC on a key1 press while sw17=1.
  - ADJ_SEC -> ADJ_MIN -> ADJ_HOUR -> RUN on successive key1 presses.
  - Any state -> RUN when sw17=0, registered the next cycle.
- adjust outputs: RUN=3, ADJ_SEC=0, ADJ_MIN=1, ADJ_HOUR=2.
- key2/key3 pulses are produced only in ADJ_* states; in RUN they are 0.
- Simultaneous key2 and key3 press events in the same cycle: both suppressed.
- A key1 press in the same cycle as a key2/key3 event: key1 wins and the inc/dec pulse is dropped.
- Prescaler: counts 0..CLK_HZ-1 and wraps; tick_1hz=1 when the count is CLK_HZ-1.
- sec_en = tick_1hz AND state==RUN. Counters are frozen during adjust.
- On the ADJ_HOUR->RUN transition, or an sw17 forced exit, the prescaler clears to 0, so the first second after adjusting is a full second.
- blink = (prescaler < CLK_HZ/2) AND state!=RUN; forced 0 in RUN.

## Timing
- Reset values:
  - state RUN, prescaler 0
  - debounced levels 1, repeat counters 0
  - tick_1hz 0, sec_en 0, adjust 2'd3, key2 0, key3 0, blink 0
- A clean raw edge reaches the synchronized level 2 cycles later. The debounced level changes DEB_CYC cycles after that. Output pulses and state changes are registered 1 cycle after the debounced edge, for a total of DEB_CYC+3 cycles from the raw edge.
- key2/key3 are exactly 1 cycle wide.
- adjust changes in the same cycle the state register changes.
- The first tick_1hz after reset occurs at cycle CLK_HZ (count CLK_HZ-1).
- Reset asserted mid-adjust: immediate return to RUN and adjust=3. No pulse is emitted on reset release, even if a button is held.

## Configuration
- `CLOCK_ADJ_AUTO_REPEAT_EN` defined:
  - While key2 (or key3) stays debounced-low in an ADJ_* state, an additional pulse fires REP_DLY cycles after the initial press pulse, then every REP_PER cycles until release.
  - Repeat timing restarts on each new press.
  - Repeat does not apply to key1.
- Undefined: exactly one pulse per press; the repeat logic is not compiled in.

## Test plan
All scenarios use CLK_HZ=10, DEB_CYC=4, REP_DLY=20, REP_PER=5.
- Reset, then run 30 cycles idle -> tick_1hz pulses at cycles 10, 20, 30; sec_en equals tick_1hz; adjust=3; blink=0.
- sw17=1, clean key1 press -> state ADJ_SEC 7 cycles after the raw edge, adjust=0, sec_en stays 0. Three more presses -> adjust 1, 2, then 3, and the prescaler reads 0 on the cycle after RUN is re-entered.
- In ADJ_MIN, key2 raw input bouncing 0/1 every 2 cycles for 12 cycles, then held low -> exactly one key2 pulse, 7 cycles after the final stable edge.
- In ADJ_SEC, key2 and key3 pressed on the same cycle -> no key2/key3 pulse. key1 and key2 pressed on the same cycle -> state advances to ADJ_MIN with no key2 pulse.
- In ADJ_HOUR, drop sw17 to 0 -> next cycle adjust=3, blink=0; key2 presses produce no pulse. Assert rst_n low mid-adjust -> all outputs at reset values.
- With CLOCK_ADJ_AUTO_REPEAT_EN, hold key3 for 40 cycles after the first pulse -> pulses at +0, +20, +25, +30, +35, +40. Without the macro -> a single pulse.
